// File: rtl/rc5_key_mixer.sv
// RC5-32/12/16 key-schedule back end: loads L from upstream, builds S from P/Q,
// runs the 3*max(t,c) mixing loop and serves the expanded table on a registered read port.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD_L | stepping L_address and capturing upstream words (one-cycle pipeline)
// INIT_S | filling S[k] = P + k*Q, one word per cycle
// MIX    | one A/B mixing iteration per cycle
// DONE   | S table complete and frozen; start reruns the schedule
module rc5_key_mixer #(
  parameter int w        = 32,
  parameter int r        = 12,
  parameter int t        = 2 * (r + 1),
  parameter int t_length = $clog2(t),
  parameter int c        = 4,
  parameter int c_length = 2,
  parameter logic [w-1:0] P = 32'hB7E15163,
  parameter logic [w-1:0] Q = 32'h9E3779B9
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                start,
  output logic [c_length-1:0] L_address,
  input  logic [w-1:0]        L_sub_i,
  output logic                busy,
  output logic                done,
  input  logic [t_length-1:0] S_address,
  output logic [w-1:0]        S_sub_i
);

  localparam int mix_n = 3 * ((t > c) ? t : c);
  localparam int cnt_w = $clog2(mix_n + 1);
  localparam int sh_w  = $clog2(w);

  localparam logic [cnt_w-1:0]    load_last = cnt_w'(c);
  localparam logic [cnt_w-1:0]    init_last = cnt_w'(t - 1);
  localparam logic [cnt_w-1:0]    mix_last  = cnt_w'(mix_n - 1);
  localparam logic [t_length-1:0] s_last    = t_length'(t - 1);
  localparam logic [c_length-1:0] l_last    = c_length'(c - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_L,
    INIT_S,
    MIX,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic   start_ok;

  logic [cnt_w-1:0]    cnt_q;
  logic [w-1:0]        init_word_q;
  logic [w-1:0]        a_q, b_q;
  logic [t_length-1:0] i_q;
  logic [c_length-1:0] j_q;

  logic [w-1:0] s_mem [t];
  logic [w-1:0] l_mem [c];

  logic [w-1:0]        sum_a, sum_b, a_next, b_next;
  logic [c_length-1:0] l_cap_addr;

  function automatic logic [w-1:0] rotl(input logic [w-1:0] x, input logic [sh_w-1:0] n);
    // a shift by the full width yields zero, so n==0 degenerates to x
    return (x << n) | (x >> (w - int'(n)));
  endfunction

  always_ff @(posedge clk1) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD_L;
          start_ok = 1'b1;
        end
      end
      LOAD_L: begin
        busy = 1'b1;
        if (cnt_q == load_last) state_d = INIT_S;
      end
      INIT_S: begin
        busy = 1'b1;
        if (cnt_q == init_last) state_d = MIX;
      end
      MIX: begin
        busy = 1'b1;
        if (cnt_q == mix_last) state_d = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_d  = LOAD_L;
          start_ok = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // B' depends on A' of the same iteration; both land in one cycle
  always_comb begin
    sum_a  = s_mem[i_q] + a_q + b_q;
    a_next = rotl(sum_a, sh_w'(3));
    sum_b  = l_mem[j_q] + a_next + b_q;
    b_next = rotl(sum_b, a_next[sh_w-1:0] + b_q[sh_w-1:0]);
  end

  assign l_cap_addr = cnt_q[c_length-1:0] - 1'b1;

  always_ff @(posedge clk1) begin
    if (!rst) begin
      cnt_q       <= '0;
      L_address   <= '0;
      init_word_q <= P;
      a_q         <= '0;
      b_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      S_sub_i     <= '0;
    end else begin
      S_sub_i <= (S_address <= s_last) ? s_mem[S_address] : '0;
      if (start_ok) begin
        cnt_q       <= '0;
        L_address   <= '0;
        init_word_q <= P;
      end else begin
        case (state_q)
          LOAD_L: begin
            L_address <= L_address + 1'b1;
            cnt_q     <= (cnt_q == load_last) ? '0 : cnt_q + 1'b1;
          end
          INIT_S: begin
            init_word_q <= init_word_q + Q;
            if (cnt_q == init_last) begin
              cnt_q <= '0;
              a_q   <= '0;
              b_q   <= '0;
              i_q   <= '0;
              j_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          MIX: begin
            a_q   <= a_next;
            b_q   <= b_next;
            i_q   <= (i_q == s_last) ? '0 : i_q + 1'b1;
            j_q   <= (j_q == l_last) ? '0 : j_q + 1'b1;
            cnt_q <= (cnt_q == mix_last) ? '0 : cnt_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Table storage carries no reset; contents only matter once DONE is reached
  always_ff @(posedge clk1) begin
    if (rst) begin
      case (state_q)
        LOAD_L: if (cnt_q != '0) l_mem[l_cap_addr] <= L_sub_i;
        INIT_S: s_mem[cnt_q[t_length-1:0]] <= init_word_q;
        MIX: begin
          s_mem[i_q] <= a_next;
          l_mem[j_q] <= b_next;
        end
        default: ;
      endcase
    end
  end

endmodule
